counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Sequencer for the 4-digit BCD counter (0000-9999) in the alarm clock.
//  - Turns raw start/stop/clear buttons into one-clk count and clear pulses.
//  - Prescales the system clock down to the count rate.
//  - Watches the counter value and raises the alarm when it equals a BCD setpoint.
//  - Sits between the board buttons and the counter's reloj/reseteador inputs.
// PARAMETERS
//  PRESCALE     50_000_000  clk cycles per count tick (>=2)
//  ALARM_TICKS  10          ring duration, in count ticks (>=1)
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  reseteador  in   1   reset, asynchronous, active-high
//  btn_start   in   1   raw async button, start/resume
//  btn_stop    in   1   raw async button, pause / alarm acknowledge
//  btn_clr     in   1   raw async button, clear counter
//  alarm_en    in   1   alarm armed (level, quasi-static)
//  alarm_bcd   in   16  setpoint {d3,d2,d1,d0}, 4-bit BCD per digit
//  cnt_b0..b3  in   4   each; counter digits fed back (b0 = units)
//  cnt_pulse   out  1   one-clk pulse; drives counter reloj
//  cnt_clr     out  1   one-clk pulse; ORed into counter reseteador
//  alarm       out  1   high while ringing
//  state       out  2   current FSM state
// BEHAVIOUR
//  Reset values
//   - state=IDLE; cnt_pulse, cnt_clr, alarm = 0; prescaler=0; ring counter=0.
//   - Reset mid-operation aborts everything immediately (asynchronous).
//  Buttons
//   - Each button: 2-flop synchroniser + 1 history flop.
//   - Event = sync & ~hist, one clk wide.
//   - Sampling edge k -> FSM reacts on edge k+2.
//  Event priority: clr > stop > start > match.
//  FSM states: IDLE=0, RUN=1, PAUSE=2, ALARM=3
//   - any   --clr-->                          IDLE; cnt_clr=1 next cycle; prescaler=0; alarm=0
//   - IDLE  --start-->                        RUN; prescaler starts at 0
//   - RUN   --stop-->                         PAUSE; prescaler holds its value
//   - PAUSE --start-->                        RUN; prescaler resumes from held phase
//   - RUN   --match_rise & alarm_en-->        ALARM; ring=ALARM_TICKS
//   - ALARM --stop, or ring==0 at a tick-->   RUN; alarm=0 next cycle
//   - start in RUN/ALARM ignored; stop in IDLE/PAUSE ignored.
//  Prescaler
//   - Counts 0..PRESCALE-1 in RUN and ALARM only; tick at PRESCALE-1, then wraps to 0.
//   - Registered cnt_pulse=1 for the cycle after the tick, in RUN and ALARM.
//   - Counting continues while ringing.
//   - First pulse arrives PRESCALE clks after entering RUN from IDLE.
//  Match
//   - match = ({b3,b2,b1,b0}==alarm_bcd); registered into match_q.
//   - match_rise = match & ~match_q.
//   - Rise-only: resuming from PAUSE while already equal does not re-ring.
//   - A non-BCD setpoint digit (>9) never matches.
//  Ring counter
//   - Decrements on each tick in ALARM.
//   - alarm follows (state==ALARM), registered.
//  Simultaneous events
//   - clr+start -> IDLE.
//   - stop+match in RUN -> PAUSE, no ring.
//   - clr during ALARM -> IDLE, alarm=0.
//  Widths
//   - Prescaler: $clog2(PRESCALE).
//   - Ring counter: $clog2(ALARM_TICKS+1).
//   - No arithmetic on BCD here; the counter owns digit wrap 9999->0000.
// STRUCTURE
//  - counter_ctrl_defs.vh: state encodings (S_IDLE..S_ALARM), shared with display/LED logic.
//  - Sub-module btn_sync_edge (sync + edge detect), instantiated 3x.
//  - Top holds FSM, prescaler, ring counter, match register.
// TESTING (PRESCALE=4, ALARM_TICKS=3; bench models counter from cnt_pulse/cnt_clr)
//  1. Reset released, no buttons -> state=0, all outputs 0 for 100 clks.
//  2. start pulse -> state=1 on edge k+2; cnt_pulse 1-clk wide every 4 clks; count 0000->0010 after 40 clks.
//  3. stop at prescaler=2, start later -> no pulses in PAUSE; first pulse after resume at exactly 2 more clks.
//  4. alarm_bcd=16'h0005, alarm_en=1 -> alarm rises 1 clk after counter hits 0005;
//     stays high for 3 ticks; state back to 1; count keeps going to 0008.
//  5. stop during ALARM -> alarm=0 on 2nd clk after event; state=1; no re-ring while value stays 0005.
//  6. clr+start same clk while counter=0042 -> state=0; one cnt_clr pulse; counter=0000;
//     reseteador asserted mid-RUN -> instant reset values.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the alarm-clock counter sequencer: FSM state
// encodings (also used by display/LED logic) and a BCD validity helper.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // True when every nibble of a 4-digit BCD word is 0..9.
    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
               (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Link between the sequencer and the 4-digit BCD counter: count/clear
// pulses going out, the four counter digits coming back.
interface counter_ctrl_if;
    logic       cnt_pulse;
    logic       cnt_clr;
    logic [3:0] cnt_b0;
    logic [3:0] cnt_b1;
    logic [3:0] cnt_b2;
    logic [3:0] cnt_b3;

    modport master (output cnt_pulse, cnt_clr,
                    input  cnt_b0, cnt_b1, cnt_b2, cnt_b3);
    modport slave  (input  cnt_pulse, cnt_clr,
                    output cnt_b0, cnt_b1, cnt_b2, cnt_b3);
endinterface

// File: rtl/counter_ctrl_btn_sync_edge.sv
// Raw button synchroniser (two flops) plus a history flop; emits a one-clock
// pulse on each synchronised rising edge.
module counter_ctrl_btn_sync_edge (
    input  logic clk,
    input  logic reseteador,
    input  logic btn,
    output logic ev
);
    logic sync1;
    logic sync2;
    logic hist;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk or posedge reseteador) begin
        if (reseteador) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign ev = sync2 & ~hist;
endmodule

// File: rtl/counter_ctrl.sv
// Alarm-clock counter sequencer: button events drive the run/pause/alarm FSM,
// a prescaler paces count pulses, and a setpoint compare rings the alarm.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE    = 50_000_000,
    parameter int ALARM_TICKS = 10
) (
    input  logic           clk,
    input  logic           reseteador,
    input  logic           btn_start,
    input  logic           btn_stop,
    input  logic           btn_clr,
    input  logic           alarm_en,
    input  logic [15:0]    alarm_bcd,
    counter_ctrl_if.master cnt,
    output logic           alarm,
    output logic [1:0]     state
);
    localparam int PW = $clog2(PRESCALE);
    localparam int RW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] RING_INIT = RW'(ALARM_TICKS);

    logic ev_start, ev_stop, ev_clr;

    counter_ctrl_btn_sync_edge u_start (.clk(clk), .reseteador(reseteador), .btn(btn_start), .ev(ev_start));
    counter_ctrl_btn_sync_edge u_stop  (.clk(clk), .reseteador(reseteador), .btn(btn_stop),  .ev(ev_stop));
    counter_ctrl_btn_sync_edge u_clr   (.clk(clk), .reseteador(reseteador), .btn(btn_clr),   .ev(ev_clr));

    state_t        cur_state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [RW-1:0] ring, ring_nxt;
    logic          match, match_q, match_rise;
    logic          run_on, tick;

    assign match = bcd_valid(alarm_bcd) &&
                   ({cnt.cnt_b3, cnt.cnt_b2, cnt.cnt_b1, cnt.cnt_b0} == alarm_bcd);
    assign match_rise = match & ~match_q;

    // The prescaler only advances on cycles that stay in a counting state, so
    // a stop freezes the phase and a clear can never leak a final pulse.
    assign run_on = ((cur_state == S_RUN) && !ev_clr && !ev_stop) ||
                    ((cur_state == S_ALARM) && !ev_clr);
    assign tick   = run_on && (presc == PRE_LAST);

    // NOTE: defaults first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = cur_state;
        ring_nxt  = ring;
        presc_nxt = presc;

        case (cur_state)
            S_IDLE:  if (ev_start) state_nxt = S_RUN;
            S_RUN: begin
                if (ev_stop) begin
                    state_nxt = S_PAUSE;
                end else if (match_rise && alarm_en) begin
                    state_nxt = S_ALARM;
                    ring_nxt  = RING_INIT;
                end
            end
            S_PAUSE: if (ev_start) state_nxt = S_RUN;
            S_ALARM: begin
                if (ev_stop) begin
                    state_nxt = S_RUN;
                end else if (tick) begin
                    ring_nxt = ring - RW'(1);
                    if (ring == RW'(1)) state_nxt = S_RUN;
                end
            end
        endcase

        if (ev_clr) state_nxt = S_IDLE;
        if (state_nxt != S_ALARM) ring_nxt = '0;

        if (run_on) presc_nxt = tick ? '0 : presc + PW'(1);
        if (ev_clr) presc_nxt = '0;
    end

    always_ff @(posedge clk or posedge reseteador) begin
        if (reseteador) begin
            cur_state     <= S_IDLE;
            presc         <= '0;
            ring          <= '0;
            match_q       <= 1'b0;
            cnt.cnt_pulse <= 1'b0;
            cnt.cnt_clr   <= 1'b0;
            alarm         <= 1'b0;
        end else begin
            cur_state     <= state_nxt;
            presc         <= presc_nxt;
            ring          <= ring_nxt;
            match_q       <= match;
            cnt.cnt_pulse <= tick;
            cnt.cnt_clr   <= ev_clr;
            alarm         <= (state_nxt == S_ALARM);
        end
    end

    assign state = cur_state;
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic, each
// cycle compared against a behavioural model of the sequencer and the BCD counter.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int P  = 4;
    localparam int AT = 3;

    logic        clk = 1'b0;
    logic        reseteador = 1'b1;
    logic        btn_start = 1'b0, btn_stop = 1'b0, btn_clr = 1'b0;
    logic        alarm_en = 1'b0;
    logic [15:0] alarm_bcd = 16'hFFFF;
    logic        alarm;
    logic [1:0]  state;

    counter_ctrl_if cif ();

    counter_ctrl #(.PRESCALE(P), .ALARM_TICKS(AT)) dut (
        .clk(clk), .reseteador(reseteador),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_clr(btn_clr),
        .alarm_en(alarm_en), .alarm_bcd(alarm_bcd),
        .cnt(cif.master), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Counter: clocked by cnt_pulse, cleared by reseteador | cnt_clr.
    int  count = 0;
    wire ctr_rst = reseteador | cif.cnt_clr;
    always @(posedge cif.cnt_pulse or posedge ctr_rst)
        if (ctr_rst) count <= 0;
        else         count <= (count + 1) % 10000;
    assign cif.cnt_b0 = 4'(count % 10);
    assign cif.cnt_b1 = 4'((count / 10) % 10);
    assign cif.cnt_b2 = 4'((count / 100) % 10);
    assign cif.cnt_b3 = 4'((count / 1000) % 10);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int d = 3; d >= 0; d--) begin
            if (v[d*4 +: 4] > 4'd9) return -1;
            r = r * 10 + int'(v[d*4 +: 4]);
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model. mode: 0 idle, 1 run, 2 pause, 3 alarm.
    int m_mode, m_phase, m_ring;
    bit m_match_prev;
    bit e_pulse, e_clr, e_alarm;
    bit smp [3][3];   // [button: start,stop,clr][age: 1,2,3 clocks ago]

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_ring = 0; m_match_prev = 0;
        e_pulse = 0; e_clr = 0; e_alarm = 0;
        for (int b = 0; b < 3; b++) for (int a = 0; a < 3; a++) smp[b][a] = 0;
    endtask

    task automatic model_step();
        bit ev [3];
        bit raw [3];
        bit match, rise, tick, keep;
        int nm;
        raw[0] = btn_start; raw[1] = btn_stop; raw[2] = btn_clr;
        for (int b = 0; b < 3; b++) begin
            ev[b] = smp[b][1] & ~smp[b][2];   // raw two clocks ago rose
            smp[b][2] = smp[b][1];
            smp[b][1] = smp[b][0];
            smp[b][0] = raw[b];
        end
        match = (bcd2int(alarm_bcd) == count);
        rise  = match && !m_match_prev;
        m_match_prev = match;
        nm = m_mode;
        if (ev[2]) nm = 0;
        else if (m_mode == 0 && ev[0]) nm = 1;
        else if (m_mode == 1 && ev[1]) nm = 2;
        else if (m_mode == 1 && rise && alarm_en) begin nm = 3; m_ring = AT; end
        else if (m_mode == 2 && ev[0]) nm = 1;
        else if (m_mode == 3 && ev[1]) nm = 1;
        keep = (m_mode == 1 || m_mode == 3) && (nm == 1 || nm == 3);
        tick = 0;
        if (keep) begin
            m_phase = (m_phase + 1) % P;
            tick = (m_phase == 0);
        end
        if (ev[2]) m_phase = 0;
        if (m_mode == 3 && nm == 3 && tick) begin
            m_ring--;
            if (m_ring == 0) nm = 1;
        end
        e_pulse = tick;
        e_clr   = ev[2];
        m_mode  = nm;
        e_alarm = (nm == 3);
    endtask

    task automatic step();
        @(posedge clk);
        if (reseteador) model_reset();
        else            model_step();
        @(negedge clk);
        check("state", 32'(state), 32'(m_mode));
        check("cnt_pulse", 32'(cif.cnt_pulse), 32'(e_pulse));
        check("cnt_clr", 32'(cif.cnt_clr), 32'(e_clr));
        check("alarm", 32'(alarm), 32'(e_alarm));
    endtask

    task automatic press(input int b);
        if (b == 0) btn_start = 1'b1; else if (b == 1) btn_stop = 1'b1; else btn_clr = 1'b1;
        repeat (3) step();
        btn_start = 1'b0; btn_stop = 1'b0; btn_clr = 1'b0;
    endtask

    int  g, n, pulses, clrs;
    bit  seen;

    initial begin
        model_reset();
        repeat (3) step();
        reseteador = 1'b0;

        // Idle after reset
        repeat (100) step();
        check("t1_count", 32'(count), 0);

        // Start, then 40 clocks of counting
        press(0);
        check("t2_state", 32'(state), 1);
        repeat (40) step();
        check("t2_count", 32'(count), 10);

        // Stop with prescaler phase 2, resume
        g = 0;
        while (m_phase != 0 && g < 20) begin step(); g++; end
        btn_stop = 1'b1; step(); btn_stop = 1'b0; step(); step();
        check("t3_pause", 32'(state), 2);
        pulses = 0;
        repeat (20) begin step(); pulses += int'(cif.cnt_pulse); end
        check("t3_pause_pulses", 32'(pulses), 0);
        press(0);
        check("t3_resumed", 32'(state), 1);
        n = 0;
        do begin step(); n++; end while (!cif.cnt_pulse && n < 10);
        check("t3_resume_gap", 32'(n), 2);

        // Alarm at 0005, rings for 3 ticks
        press(2);
        check("t4_cleared", 32'(count), 0);
        alarm_bcd = 16'h0005; alarm_en = 1'b1;
        press(0);
        g = 0;
        while (!alarm && g < 100) begin step(); g++; end
        check("t4_alarm_at", 32'(count), 5);
        pulses = 0; g = 0;
        while (alarm && g < 100) begin step(); pulses += int'(cif.cnt_pulse); g++; end
        check("t4_ring_ticks", 32'(pulses), 3);
        check("t4_count", 32'(count), 8);
        check("t4_state", 32'(state), 1);

        // Stop acknowledges the alarm, no re-ring
        press(2);
        press(0);
        g = 0;
        while (count != 5 && g < 100) begin step(); g++; end
        btn_stop = 1'b1; step(); btn_stop = 1'b0; step(); step();
        check("t5_alarm", 32'(alarm), 0);
        check("t5_state", 32'(state), 1);
        check("t5_count", 32'(count), 5);
        seen = 0;
        repeat (12) begin step(); seen |= alarm; end
        check("t5_no_rering", 32'(seen), 0);

        // clr+start together at 0042
        alarm_en = 1'b0;
        g = 0;
        while (count != 42 && g < 400) begin step(); g++; end
        check("t6_reach42", 32'(count), 42);
        btn_clr = 1'b1; btn_start = 1'b1;
        clrs = 0;
        repeat (3) begin step(); clrs += int'(cif.cnt_clr); end
        btn_clr = 1'b0; btn_start = 1'b0;
        check("t6_state", 32'(state), 0);
        repeat (5) begin step(); clrs += int'(cif.cnt_clr); end
        check("t6_clr_pulses", 32'(clrs), 1);
        check("t6_count", 32'(count), 0);

        // Asynchronous reset mid-RUN
        press(0);
        repeat (10) step();
        @(posedge clk);
        #2 reseteador = 1'b1;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_pulse", 32'(cif.cnt_pulse), 0);
        check("rst_clr", 32'(cif.cnt_clr), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_count", 32'(count), 0);
        repeat (2) step();
        reseteador = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            btn_start = ($urandom_range(0, 19) == 0);
            btn_stop  = ($urandom_range(0, 24) == 0);
            btn_clr   = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 63) == 0) alarm_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                alarm_bcd = int2bcd((count + int'($urandom_range(1, 4))) % 10000);
                if ($urandom_range(0, 7) == 0) alarm_bcd[3:0] = 4'($urandom_range(10, 15));
            end
            if ($urandom_range(0, 1499) == 0) begin
                reseteador = 1'b1;
                repeat (2) step();
                reseteador = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
